// File: rtl/keypad_press_gen.sv
// ============================================================================
//  Module      : keypad_press_gen
//  Description : Turns 4-bit key codes into timed one-hot keypad line
//                presses. Each accepted code is held on its key line for
//                PRESS_CYCLES cycles, followed by GAP_CYCLES all-zero cycles.
//                Invalid codes (4'hC..4'hF) raise a one-cycle err pulse
//                instead of a press.
//  Options     : define KEYPAD_PRESS_GEN_FIFO_EN to place a 4-entry FIFO
//                between the input handshake and the press sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_press_gen #(
  parameter int unsigned PRESS_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_code,
  output logic        in_ready,
  output logic [11:0] keypad_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Counter reload values: the counter runs from PARAM-1 down to 0.
  localparam logic [15:0] c_press_load = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] c_gap_load   = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [11:0] r_key;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  // Code presented to the sequencer and the strobe that says it is taken.
  logic        w_start;
  logic [3:0]  w_code;
  logic        w_code_ok;

  // Map a key code onto its keypad line; invalid codes map to all-zero.
  function automatic logic [11:0] f_decode(input logic [3:0] code);
    logic [11:0] v;
    v = '0;
    case (code)
      4'h0:    v[10] = 1'b1;
      4'h1:    v[0]  = 1'b1;
      4'h2:    v[1]  = 1'b1;
      4'h3:    v[2]  = 1'b1;
      4'h4:    v[3]  = 1'b1;
      4'h5:    v[4]  = 1'b1;
      4'h6:    v[5]  = 1'b1;
      4'h7:    v[6]  = 1'b1;
      4'h8:    v[7]  = 1'b1;
      4'h9:    v[8]  = 1'b1;
      4'hA:    v[9]  = 1'b1;
      4'hB:    v[11] = 1'b1;
      default: v     = '0;
    endcase
    return v;
  endfunction

  assign w_code_ok = (w_code <= 4'hB);

`ifdef KEYPAD_PRESS_GEN_FIFO_EN
  // ------------------------------------------------------------------------
  // Buffered input: codes queue up while a press/gap is running, and the
  // sequencer pops one whenever it sits in IDLE.
  // ------------------------------------------------------------------------
  logic [3:0] r_mem [0:3];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign in_ready = rst && (r_count != 3'd4);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == ST_IDLE) && (r_count != 3'd0);
  assign w_start  = w_pop;
  assign w_code   = r_mem[r_rd_ptr];

  // FIFO storage and pointers; a simultaneous push and pop leaves the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_code;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  // ------------------------------------------------------------------------
  // Direct input: the sequencer takes a code straight from the handshake,
  // and only while it is idle.
  // ------------------------------------------------------------------------
  assign in_ready = rst && (r_state == ST_IDLE);
  assign w_start  = in_valid && in_ready;
  assign w_code   = in_code;
`endif

  // Press sequencer: IDLE -> PRESS -> GAP -> IDLE, outputs registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_key   <= 12'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_code_ok) begin
              r_state <= ST_PRESS;
              r_cnt   <= c_press_load;
              r_key   <= f_decode(w_code);
              r_busy  <= 1'b1;
            end else begin
              // Invalid code: flag it where the press would have begun.
              r_err <= 1'b1;
            end
          end
        end
        ST_PRESS: begin
          if (r_cnt == 16'd0) begin
            r_state <= ST_GAP;
            r_cnt   <= c_gap_load;
            r_key   <= 12'd0;
            // A one-cycle gap is also the last gap cycle.
            r_done  <= (c_gap_load == 16'd0);
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 16'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - 16'd1;
            // done lands on the cycle where the counter reads zero.
            r_done <= (r_cnt == 16'd1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'd0;
          r_key   <= 12'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign keypad_out = r_key;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_keypad_press_gen.sv
// ============================================================================
//  Module      : tb_keypad_press_gen
//  Description : Self-checking bench for keypad_press_gen. A schedule-based
//                reference model predicts every output per cycle; directed
//                sequences add literal expectations, then random traffic
//                with occasional resets runs against the model.
//                Honours KEYPAD_PRESS_GEN_FIFO_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_press_gen;

  localparam int P  = 4;
  localparam int G  = 2;
  localparam int NC = 8192;
`ifdef KEYPAD_PRESS_GEN_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_code = 4'd0;
  logic        in_ready;
  logic [11:0] keypad_out;
  logic        busy, done, err;

  logic        v2 = 1'b0;
  logic [3:0]  c2 = 4'd0;
  logic        rdy2;
  logic [11:0] key2;
  logic        busy2, done2, err2;

  keypad_press_gen #(.PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .keypad_out(keypad_out), .busy(busy),
    .done(done), .err(err)
  );

  keypad_press_gen #(.PRESS_CYCLES(1), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_code(c2),
    .in_ready(rdy2), .keypad_out(key2), .busy(busy2),
    .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model: per-cycle expected schedule ----------
  int         cyc = 0;       // index of the next rising edge
  int         free_at = 0;   // first edge at which a new code can start
  bit [11:0]  e_key  [NC];
  bit         e_busy [NC];
  bit         e_done [NC];
  bit         e_err  [NC];
  logic [3:0] q [$];

  function automatic bit [11:0] keymap(input logic [3:0] code);
    bit [11:0] one;
    one = 12'h001;
    case (code)
      4'h0:    return 12'h400;
      4'hA:    return 12'h200;
      4'hB:    return 12'h800;
      default: return one << (code - 4'd1);
    endcase
  endfunction

  // A code starting at edge m is visible from the interval after edge m.
  function automatic void schedule(input int m, input logic [3:0] code);
    if (code <= 4'hB) begin
      for (int i = 0; i < P + G; i++) begin
        if (m + i < NC) begin
          e_busy[m + i] = 1'b1;
          if (i < P) e_key[m + i] = keymap(code);
        end
      end
      if (m + P + G - 1 < NC) e_done[m + P + G - 1] = 1'b1;
      free_at = m + P + G + 1;
    end else begin
      if (m < NC) e_err[m] = 1'b1;
      free_at = m + 1;
    end
  endfunction

  task automatic model_edge();
    int n;
    bit rdy;
    n = cyc;
    if (!rst) begin
      for (int i = n; i < n + P + G + 2 && i < NC; i++) begin
        e_key[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
      end
      free_at = n + 1;
      q.delete();
    end else begin
`ifdef KEYPAD_PRESS_GEN_FIFO_EN
      rdy = (q.size() < 4);
      if (q.size() > 0 && n >= free_at) schedule(n, q.pop_front());
      if (in_valid && rdy) q.push_back(in_code);
`else
      rdy = (n >= free_at);
      if (in_valid && rdy) schedule(n, in_code);
`endif
    end
    cyc = n + 1;
  endtask

  function automatic bit pred_ready();
`ifdef KEYPAD_PRESS_GEN_FIFO_EN
    return rst && (q.size() < 4);
`else
    return rst && (cyc >= free_at);
`endif
  endfunction

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Compare process: registered outputs after each edge, in_ready mid-cycle.
  always @(posedge clk) begin
    int k;
    model_edge();
    #1;
    k = cyc - 1;
    if (k < NC) begin
      chk12("model_keypad_out", keypad_out, e_key[k]);
      chk1("model_busy", busy, e_busy[k]);
      chk1("model_done", done, e_done[k]);
      chk1("model_err", err, e_err[k]);
    end
    @(negedge clk);
    #1;
    chk1("model_in_ready", in_ready, pred_ready());
  end

  // ---------------- stimulus helpers (called at a falling edge) -----------
  task automatic send(input logic [3:0] code);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 4'($urandom);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got no in_ready expected in_ready within 200 cycles");
    end
  endtask

  task automatic send2(input logic [3:0] code);
    bit ok;
    ok = 1'b0;
    v2 = 1'b1;
    c2 = code;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (rdy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    v2 = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send2_timeout: got no in_ready expected in_ready within 200 cycles");
    end
  endtask

  bit [11:0] k030 [6] = '{12'h001, 12'h001, 12'h001, 12'h001, 12'h000, 12'h000};
  bit        d030 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  bit [11:0] k031 [4] = '{12'h400, 12'h200, 12'h800, 12'h100};
  logic [3:0] c031 [4] = '{4'h0, 4'hA, 4'hB, 4'h9};

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk12("rst_keypad_out", keypad_out, 12'h000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_in_ready2", rdy2, 1'b0);

    // Code 1 immediately on reset release.
    @(negedge clk);
    rst = 1'b1;
    send(4'h1);
    repeat (LAT - 1) begin
      #1; chk12("lit1_lead", keypad_out, 12'h000);
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      chk12("lit1_key", keypad_out, k030[i]);
      chk1("lit1_done", done, d030[i]);
      chk1("lit1_busy", busy, 1'b1);
      @(negedge clk);
    end
    #1;
    chk1("lit1_busy_end", busy, 1'b0);

    // Invalid code 4'hE.
    @(negedge clk);
    send(4'hE);
    repeat (LAT - 1) @(negedge clk);
    #1;
    chk1("litE_err", err, 1'b1);
    chk12("litE_key", keypad_out, 12'h000);
    chk1("litE_busy", busy, 1'b0);
    chk1("litE_ready", in_ready, 1'b1);
    @(negedge clk);
    #1;
    chk1("litE_err_end", err, 1'b0);

    // Reset during the third press cycle of code 7, then code 3.
    @(negedge clk);
    send(4'h7);
    repeat (LAT - 1) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    chk12("lit7_key", keypad_out, 12'h040);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk12("lit7_abort_key", keypad_out, 12'h000);
    chk1("lit7_abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    send(4'h3);
    repeat (LAT - 1) @(negedge clk);
    #1;
    chk12("lit3_key", keypad_out, 12'h004);

    // Sequence 0, *, #, 9.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      send(c031[j]);
      repeat (LAT - 1) @(negedge clk);
      #1;
      chk12("lit_seq_key", keypad_out, k031[j]);
    end

    // Stream codes 1..6 on consecutive cycles regardless of in_ready.
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_code  = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (70) @(negedge clk);

    // Minimum timing instance: codes 2, 2.
    for (int j = 0; j < 2; j++) begin
      send2(4'h2);
      repeat (LAT - 1) @(negedge clk);
      #1;
      chk12("min_key_press", key2, 12'h002);
      chk1("min_done_press", done2, 1'b0);
      @(negedge clk);
      #1;
      chk12("min_key_gap", key2, 12'h000);
      chk1("min_done_gap", done2, 1'b1);
      @(negedge clk);
    end

    // Random traffic with occasional resets.
    repeat (1500) begin
      rst      = ($urandom_range(0, 149) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) in_code = 4'($urandom_range(0, 15));
      else                           in_code = 4'($urandom_range(0, 11));
      @(negedge clk);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_press_gen.md
KEYPAD_PRESS_GEN -- requirements
Module: keypad_press_gen

Interface
REQ-001 Parameter PRESS_CYCLES, default 4: cycles a key line is held high per press; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 2: all-zero cycles after each press; legal range 1..65535.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  a key code is offered on in_code.
REQ-006 in_code  input  4  key code: 0..9 are digits, 4'hA is '*', 4'hB is '#', 4'hC..4'hF are invalid.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 keypad_out  output  12  one-hot key lines (bit0 = key 1 ... bit8 = key 9, bit9 = '*', bit10 = key 0, bit11 = '#').
REQ-009 busy  output  1  a press or gap is in progress.
REQ-010 done  output  1  one-cycle pulse when a press sequence completes.
REQ-011 err  output  1  one-cycle pulse when an invalid code is executed.

Function
REQ-012 A transfer occurs when in_valid and in_ready are both high on a rising edge; in_code is captured at that edge.
REQ-013 The FSM states are IDLE, PRESS and GAP.
- IDLE to PRESS: a valid code is available.
- PRESS to GAP: after PRESS_CYCLES cycles.
- GAP to IDLE: after GAP_CYCLES cycles.
REQ-014 Code mapping: code d in 1..9 drives bit d-1; code 0 drives bit10; 4'hA drives bit9; 4'hB drives bit11; exactly one bit is high during PRESS.
REQ-015 keypad_out is registered and is all-zero in IDLE and GAP.
REQ-016 keypad_out is non-zero for exactly PRESS_CYCLES consecutive cycles per valid code.
REQ-017 done pulses high for one cycle, coincident with the last GAP cycle.
REQ-018 busy is high in PRESS and GAP and low in IDLE.
REQ-019 An invalid code (4'hC..4'hF) causes no press, no GAP and no done.
- err pulses one cycle at the point the code would have entered PRESS.
- The FSM stays in IDLE.
REQ-020 The press and gap counter is 16 bits wide, counts down from PARAM-1 to 0, and never wraps.
REQ-021 Back-to-back codes: the next PRESS begins no earlier than the cycle after the last GAP cycle, so consecutive presses are always separated by at least GAP_CYCLES zero cycles.
REQ-022 in_valid held high with in_ready low shall not cause a transfer; in_code may change freely while in_ready is low.

Reset
REQ-023 While rst is low at a rising edge:
- keypad_out = 0, busy = 0, done = 0, err = 0;
- the FSM goes to IDLE and the counter is cleared;
- the queue (if compiled in) is emptied;
- in_ready = 0 for that cycle.
REQ-024 Reset asserted mid-PRESS or mid-GAP aborts the sequence with no done pulse; the aborted code is discarded.
REQ-025 The first transfer after reset release is possible on the first edge with rst high.

Configuration
REQ-026 Macro KEYPAD_PRESS_GEN_FIFO_EN selects the input buffering.
REQ-027 Without KEYPAD_PRESS_GEN_FIFO_EN:
- in_ready = (state == IDLE) and rst high;
- a code accepted at edge t drives keypad_out from cycle t+1.
REQ-028 With KEYPAD_PRESS_GEN_FIFO_EN:
- a 4-entry FIFO sits between the handshake and the FSM, with in_ready = not full;
- the FSM pops the FIFO in IDLE when it is not empty;
- a code accepted into an empty FIFO at edge t drives keypad_out from cycle t+2;
- push and pop in the same cycle are both honoured;
- a push into a full FIFO is impossible, because in_ready is low.
REQ-029 Both builds have identical port lists and identical keypad_out and done timing relative to the start of PRESS.

Verification
REQ-030 After reset, send code 4'h1 (no FIFO build) -> keypad_out = 12'h001 for 4 cycles starting 1 cycle after the transfer, then 2 zero cycles; done pulses on the 2nd zero cycle; busy is high for 6 cycles.
REQ-031 Send codes 0, 4'hA, 4'hB, 9 in sequence -> keypad_out shows 12'h400, 12'h200, 12'h800, 12'h100 in that order, each held 4 cycles, separated by 2 zero cycles.
REQ-032 Send code 4'hE -> err pulses once; keypad_out stays 0; done stays 0; busy stays 0; the block is ready for the next code on the following cycle.
REQ-033 Drop rst low during the 3rd PRESS cycle of code 7 -> keypad_out = 0 on the next cycle; no done pulse; a subsequent code 3 produces a normal 12'h004 press.
REQ-034 FIFO build: hold in_valid high with codes 1..6 on consecutive cycles -> in_ready drops after 4 accepted (counting any concurrent pop); every accepted code is pressed once, in order, with no loss or duplication.
REQ-035 Set PRESS_CYCLES = 1 and GAP_CYCLES = 1 and stream codes 2, 2 -> keypad_out = 12'h002, 0, 12'h002, 0, with done pulsing on each zero cycle.
